// File: rtl/mdu_param.sv
// rtl/mdu_param.sv - parametrised multiply/divide unit with HI/LO registers
//
// Purpose:
//   Runs mult/multu/div/divu over a fixed latency and commits the result to
//   the architectural HI/LO registers. mthi/mtlo write HI/LO in one cycle.
//   busy lets the hazard unit stall mfhi/mflo and further MDU ops. cancel
//   discards an in-flight op, or suppresses an issue in the same cycle.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   issue request
//   op      in   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   ina     in   rs operand / dividend / mthi-mtlo data
//   inb     in   rt operand / divisor
//   cancel  in   abort in-flight op / suppress issue
//   busy    out  operation in flight
//   done    out  one-cycle pulse after a mult/div commit
//   hi, lo  out  HI / LO registers

module mdu_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Datapath works on the latched operands only, so the result is a pure
  // function of what was captured at the accepting edge.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of that product
    // are the exact signed/unsigned full product.
    a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. most-negative / -1 falls out naturally
    // as quotient most-negative, remainder 0.
    a_neg  = ~op_q[0] & a_q[WIDTH-1];
    b_neg  = ~op_q[0] & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_zero = (b_q == '0);
    b_safe = b_zero ? W_ONE : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    if (op_q[1]) begin
      res_hi = b_zero ? a_q : rem;
      res_lo = b_zero ? '1  : quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              a_d     = ina;
              b_d     = inb;
              op_d    = op[1:0];
              cnt_d   = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
              state_d = BUSY;
            end
            3'b100:  hi_d = ina;
            3'b101:  lo_d = ina;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Cancel wins even on the commit edge.
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// tb/tb_mdu_param.sv - directed self-checking bench for mdu_param

module tb_mdu_param;

  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] ina, inb;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int check_cnt = 0;

  mdu_param #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .ina    (ina),
    .inb    (inb),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    ina   = a;
    inb   = b;
    step();
    start = 1'b0;
  endtask

  // Called in the first busy cycle; returns in the done cycle.
  task automatic wait_commit(input string tag, input int lat,
                             input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    for (int i = 0; i < lat; i++) begin
      if (busy && !done) n++;
      step();
    end
    check({tag, " busy_cycles"}, n, lat);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " done"}, done, 1);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b);
    wait_commit(tag, (o[1] ? DL : ML), eh, el);
    step();
    check({tag, " done_clear"}, done, 0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'b000;
    ina    = '0;
    inb    = '0;
    cancel = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // 1: multiply
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_mix", OP_MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB);

    // 2: divide
    run_op("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_big",  OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC);
    run_op("div_negb",  OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // 3: boundaries
    run_op("divu_zero", OP_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero",  OP_DIV,  32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF);
    run_op("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // 4: mthi/mtlo back to back, no-op, ignored mthi while busy
    start = 1'b1; op = OP_MTHI; ina = 32'h12345678;
    step();
    check("mthi hi", hi, 32'h12345678);
    check("mthi busy", busy, 0);
    op = OP_MTLO; ina = 32'h9ABCDEF0;
    step();
    check("mtlo lo", lo, 32'h9ABCDEF0);
    check("mtlo hi_keep", hi, 32'h12345678);
    check("mtlo busy", busy, 0);
    op = OP_NOP; ina = 32'h0BADF00D;
    step();
    start = 1'b0;
    check("nop busy", busy, 0);
    check("nop hi", hi, 32'h12345678);
    check("nop lo", lo, 32'h9ABCDEF0);

    issue(OP_MULT, 32'd6, 32'd7);
    start = 1'b1; op = OP_MTHI; ina = 32'hDEADBEEF; inb = 32'h00000003;
    step();
    start = 1'b0;
    check("busy_mthi ignored", hi, 32'h12345678);
    wait_commit("mult_after_mthi", ML - 1, 32'h00000000, 32'h0000002A);
    step();

    // 5: cancel
    issue(OP_MTHI, 32'hAAAAAAAA, 32'h0);
    issue(OP_MTLO, 32'h55555555, 32'h0);
    issue(OP_DIV, 32'd100, 32'd3);
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel3 busy", busy, 0);
    check("cancel3 done", done, 0);
    n = 0;
    for (int i = 0; i < DL + 2; i++) begin
      if (done || busy) n++;
      step();
    end
    check("cancel3 quiet", n, 0);
    check("cancel3 hi", hi, 32'hAAAAAAAA);
    check("cancel3 lo", lo, 32'h55555555);

    issue(OP_DIV, 32'd100, 32'd3);
    for (int i = 0; i < DL - 1; i++) step();
    check("cancel_commit busy_before", busy, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_commit busy", busy, 0);
    check("cancel_commit done", done, 0);
    check("cancel_commit hi", hi, 32'hAAAAAAAA);
    check("cancel_commit lo", lo, 32'h55555555);

    start = 1'b1; cancel = 1'b1; op = OP_MTHI; ina = 32'h01010101;
    step();
    start = 1'b1; op = OP_MULT; ina = 32'd2; inb = 32'd2;
    step();
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle hi", hi, 32'hAAAAAAAA);
    check("cancel_idle busy", busy, 0);

    // 6: async reset mid-operation
    issue(OP_MULT, 32'd6, 32'd7);
    step();
    #3;
    reset = 1'b1;
    #1;
    check("areset hi", hi, 0);
    check("areset lo", lo, 0);
    check("areset busy", busy, 0);
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < ML + 3; i++) begin
      if (done || busy) n++;
      step();
    end
    check("areset no_done", n, 0);
    check("areset hi_after", hi, 0);
    check("areset lo_after", lo, 0);

    // back-to-back: second mult accepted in the done cycle
    issue(OP_MULT, 32'd3, 32'd4);
    wait_commit("b2b first", ML, 32'h0, 32'd12);
    issue(OP_MULT, 32'hFFFFFFFB, 32'd6);
    wait_commit("b2b second", ML, 32'hFFFFFFFF, 32'hFFFFFFE2);
    step();
    check("b2b done_clear", done, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
